// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: default field widths, the EX/MEM
// payload layout and the elastic-buffer state encoding.
package mips_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W  = 5;

  // Field order is the wire order of every packed EX/MEM payload vector.
  typedef struct packed {
    logic                  wb_en;
    logic                  mem_r_en;
    logic                  mem_w_en;
    logic [DEF_DATA_W-1:0] alu_result;
    logic [DEF_DATA_W-1:0] st_val;
    logic [DEF_REG_W-1:0]  dest;
  } exe_mem_t;

  // Encoding doubles as the entry count.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/skid_buf.sv
// Generic valid/ready buffer over an opaque payload: main entry M drives the
// output, optional skid entry S absorbs the beat in flight when a stall starts.
module skid_buf
  import mips_pkg::*;
#(
  parameter int W        = 8,
  parameter bit HAS_SKID = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occupancy
);

  buf_state_t   state_q, state_d;
  logic [W-1:0] m_q, m_d;
  logic [W-1:0] s_q, s_d;
  logic         put, take;

  assign out_valid = (state_q != BUF_EMPTY);
  assign out_data  = m_q;
  assign occupancy = state_q;
  assign take      = out_valid & out_ready;
  assign put       = in_valid & in_ready;

  // With a skid entry, in_ready decodes the state register only, so a stall
  // on the memory side never reaches the execute stage in the same cycle.
  generate
    if (HAS_SKID) begin : g_skid
      assign in_ready = (state_q != BUF_FULL);
    end else begin : g_single
      assign in_ready = out_ready | ~out_valid;
    end
  endgenerate

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would infer a latch.
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    unique case (state_q)
      BUF_EMPTY: begin
        if (put) begin
          state_d = BUF_ONE;
          m_d     = in_data;
        end
      end
      BUF_ONE: begin
        if (put && take) begin
          m_d = in_data;
        end else if (put) begin
          state_d = BUF_FULL;
          s_d     = in_data;
        end else if (take) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (take) begin
          state_d = BUF_ONE;
          m_d     = s_q;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
    if (flush) state_d = BUF_EMPTY;
  end

  // NOTE: non-blocking assignments for all state so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BUF_EMPTY;
      // NOTE: payload registers are reset too, so nothing stale is ever
      // visible on the data path after reset.
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

endmodule

// File: rtl/exe_mem_stage.sv
// Elastic EX->MEM stage register: skid buffer plus legacy freeze, synchronous
// flush, bubble masking and occupancy reporting.
module exe_mem_stage
  import mips_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int REG_W    = DEF_REG_W,
  parameter bit HAS_SKID = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wb_en,
  input  logic              in_mem_r_en,
  input  logic              in_mem_w_en,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_st_val,
  input  logic [REG_W-1:0]  in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wb_en,
  output logic              out_mem_r_en,
  output logic              out_mem_w_en,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_st_val,
  output logic [REG_W-1:0]  out_dest,
  input  logic              freeze,
  input  logic              flush,
  output logic [1:0]        occupancy
);

  // Same field order as exe_mem_t; with default widths PAY_W == $bits(exe_mem_t).
  localparam int PAY_W = 3 + 2 * DATA_W + REG_W;

  logic [PAY_W-1:0] in_pay, out_pay;
  logic             mem_ready;

  assign in_pay    = {in_wb_en, in_mem_r_en, in_mem_w_en, in_alu_result, in_st_val, in_dest};
  assign mem_ready = out_ready & ~freeze;

  skid_buf #(
    .W        (PAY_W),
    .HAS_SKID (HAS_SKID)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pay),
    .out_valid (out_valid),
    .out_ready (mem_ready),
    .out_data  (out_pay),
    .occupancy (occupancy)
  );

  // Bubbles present as all-zero so downstream never acts on a stale control bit.
  assign {out_wb_en, out_mem_r_en, out_mem_w_en, out_alu_result, out_st_val, out_dest} =
    out_valid ? out_pay : '0;

endmodule
